// File: rtl/fat_pkg.sv
// Shared constants and FSM state encoding for the FAT32 chain writer.
package fat_pkg;

   localparam int          BLOCK_BYTES       = 512;
   localparam int          ENTRIES_PER_BLOCK = BLOCK_BYTES / 4;
   localparam logic [8:0]  LAST_BYTE         = 9'(BLOCK_BYTES - 1);

   localparam logic [31:0] EOC_VALUE      = 32'h0FFF_FFFF;
   localparam logic [31:0] MEDIA_ENTRY    = 32'h0FFF_FFF8;  // cluster 0
   localparam logic [31:0] RESERVED_ENTRY = 32'hFFFF_FFFF;  // cluster 1

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      REQ,
      STREAM,
      WAIT_DONE,
      DONE
   } state_t;

endpackage

// File: rtl/fat_chain_writer_entry_serializer.sv
// Synthesises one FAT32 entry from (sector, byte index, EOF) and registers
// the selected little-endian byte lane whenever the stream advances.
module fatEntrySerializer
   import fat_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic [24:0] sector,
   input  logic [8:0]  byte_idx,
   input  logic [31:0] eof,
   input  logic        advance,
   output logic [7:0]  byte_data
);

   logic [31:0] clust;
   logic [31:0] entry;

   // sector * ENTRIES_PER_BLOCK + entry offset within the block
   assign clust = {sector, byte_idx[8:2]};

   always_comb begin
      // NOTE: default first so every path assigns entry and no latch is inferred.
      entry = 32'h0;
      if (clust == 32'd0)
         entry = MEDIA_ENTRY;
      else if (clust == 32'd1)
         entry = RESERVED_ENTRY;
      else if (clust < eof)
         entry = clust + 32'd1;
      else if (clust == eof)
         entry = EOC_VALUE;
   end

   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (RST)
         byte_data <= 8'h00;
      else if (advance)
         case (byte_idx[1:0])
            2'd0:    byte_data <= entry[7:0];
            2'd1:    byte_data <= entry[15:8];
            2'd2:    byte_data <= entry[23:16];
            default: byte_data <= entry[31:24];
         endcase
   end

endmodule

// File: rtl/fat_chain_writer.sv
// Writes FAT1 then FAT2 copies of every FAT sector covering one contiguous
// cluster chain, streaming synthesised sector bytes to the SD block writer.
module fat_chain_writer
   import fat_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        ENA,
   output logic        COMPLT,
   output logic        ERR,
   input  logic [31:0] FIRST_CLUST_TO_UPDATE_FAT,
   input  logic [31:0] CLUST_NUM_EOF,
   input  logic [31:0] ADDR_TO_UPDATE_FAT1,
   input  logic [31:0] ADDR_TO_UPDATE_FAT2,
   output logic        BLK_REQ,
   output logic [31:0] BLK_ADDR,
   input  logic        BLK_GNT,
   output logic [7:0]  BYTE_DATA,
   output logic        BYTE_VALID,
   input  logic        BYTE_RDY,
   input  logic        BLK_DONE
);

   state_t      state, state_nxt;

   logic [31:0] first_q, eof_q, fat1_q, fat2_q;
   logic [24:0] sec, sec_last;
   logic [31:0] k;
   logic        fat;
   logic [8:0]  b;

   logic        job_bad;
   logic        ser_advance;
   logic [8:0]  ser_idx;

   assign job_bad = (first_q < 32'd2) || (first_q > eof_q);

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (ENA) state_nxt = CHECK;
         CHECK:     state_nxt = job_bad ? DONE : REQ;
         REQ:       if (BLK_GNT) state_nxt = STREAM;
         STREAM:    if (BYTE_RDY && b == LAST_BYTE) state_nxt = WAIT_DONE;
         WAIT_DONE: if (BLK_DONE) state_nxt = (fat && sec == sec_last) ? DONE : REQ;
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Byte 0 is loaded on the grant edge; later bytes load as each one is taken.
   assign ser_advance = (state == REQ && BLK_GNT) ||
                        (state == STREAM && BYTE_RDY && b != LAST_BYTE);
   assign ser_idx     = (state == REQ) ? 9'd0 : b + 9'd1;

   always_ff @(posedge CLK) begin
      if (RST) begin
         COMPLT     <= 1'b0;
         ERR        <= 1'b0;
         BLK_REQ    <= 1'b0;
         BLK_ADDR   <= 32'h0;
         BYTE_VALID <= 1'b0;
         first_q    <= 32'h0;
         eof_q      <= 32'h0;
         fat1_q     <= 32'h0;
         fat2_q     <= 32'h0;
         sec        <= '0;
         sec_last   <= '0;
         k          <= 32'h0;
         fat        <= 1'b0;
         b          <= 9'd0;
      end else begin
         COMPLT     <= (state_nxt == DONE);
         BLK_REQ    <= (state_nxt == REQ);
         BYTE_VALID <= (state_nxt == STREAM);
         case (state)
            IDLE: if (ENA) begin
               first_q <= FIRST_CLUST_TO_UPDATE_FAT;
               eof_q   <= CLUST_NUM_EOF;
               fat1_q  <= ADDR_TO_UPDATE_FAT1;
               fat2_q  <= ADDR_TO_UPDATE_FAT2;
            end
            CHECK: begin
               ERR      <= job_bad;
               sec      <= first_q[31:7];
               sec_last <= eof_q[31:7];
               k        <= 32'h0;
               fat      <= 1'b0;
               BLK_ADDR <= fat1_q;
            end
            REQ: if (BLK_GNT) b <= 9'd0;
            STREAM: if (BYTE_RDY && b != LAST_BYTE) b <= b + 9'd1;
            WAIT_DONE: if (BLK_DONE) begin
               if (!fat) begin
                  fat      <= 1'b1;
                  BLK_ADDR <= fat2_q + k;
               end else if (sec != sec_last) begin
                  sec      <= sec + 25'd1;
                  k        <= k + 32'd1;
                  fat      <= 1'b0;
                  BLK_ADDR <= fat1_q + k + 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

   fatEntrySerializer u_serializer (
      .CLK       (CLK),
      .RST       (RST),
      .sector    (sec),
      .byte_idx  (ser_idx),
      .eof       (eof_q),
      .advance   (ser_advance),
      .byte_data (BYTE_DATA)
   );

endmodule

// File: doc/fat_chain_writer.md
# fat_chain_writer

Downstream of the file-system server. Once a logging run stops, it takes the cluster-chain results (first cluster to update, EOF cluster, FAT1/FAT2 sector addresses) and generates complete FAT32 sectors describing one contiguous file. It streams each sector byte-by-byte to the SD block-write controller, writing FAT1 then FAT2 for every affected sector. No read-back: sector contents are fully synthesised.

## Interface
- BLOCK_BYTES, 512, bytes per SD block; fixed, not retargetable.
- ENTRIES_PER_BLOCK, 128, FAT32 entries per block (BLOCK_BYTES/4).
- EOC_VALUE, 32'h0FFFFFFF, end-of-chain entry value.

- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- ENA  in  1  start request; sampled only in IDLE.
- COMPLT  out  1  one-cycle pulse when the job ends.
- ERR  out  1  valid with COMPLT: 1 = rejected job, nothing written.
- FIRST_CLUST_TO_UPDATE_FAT  in  32  first cluster whose sector is rewritten.
- CLUST_NUM_EOF  in  32  last cluster of the file.
- ADDR_TO_UPDATE_FAT1  in  32  FAT1 block address of the sector holding FIRST's entry.
- ADDR_TO_UPDATE_FAT2  in  32  FAT2 block address of the same sector.
- BLK_REQ  out  1  block-write request; held until BLK_GNT.
- BLK_ADDR  out  32  target block; stable while BLK_REQ is high.
- BLK_GNT  in  1  controller accepts the request.
- BYTE_DATA  out  8  payload byte.
- BYTE_VALID  out  1  BYTE_DATA valid.
- BYTE_RDY  in  1  controller takes a byte when VALID && RDY.
- BLK_DONE  in  1  one-cycle pulse: block committed to card.

## Operation
- IDLE: on ENA=1, latch all four inputs → CHECK. ENA is ignored in every other state.
- CHECK: if FIRST < 2 or FIRST > EOF → DONE with ERR=1. Otherwise:
  - s = FIRST>>7 (sector index)
  - sLast = EOF>>7
  - k = 0
  - fat = 0
  - → REQ
- REQ: BLK_REQ=1, BLK_ADDR = (fat ? FAT2 : FAT1) + k. On BLK_GNT → STREAM, byte counter b = 0.
- STREAM: emit bytes 0..511. Entry cluster c = s*128 + (b>>2); byte lane b[1:0] is little-endian. Entry value:
  - c==0 → 0x0FFFFFF8
  - c==1 → 0xFFFFFFFF
  - 2≤c<EOF → c+1
  - c==EOF → EOC_VALUE
  - c>EOF → 0
  - After the byte at b=511 transfers → WAIT_DONE.
- WAIT_DONE: on BLK_DONE:
  - if fat==0: fat = 1 → REQ (same sector, FAT2).
  - else if s==sLast → DONE.
  - else s++, k++, fat = 0 → REQ.
- DONE: COMPLT=1 for one cycle → IDLE. ERR keeps its value until the next job's CHECK.
- Total blocks written = 2*(sLast − FIRST>>7 + 1).
- Arithmetic: 32-bit unsigned; c+1 never wraps because EOF < 2^28 is the caller's guarantee.

## Timing
- Reset values: COMPLT=0, ERR=0, BLK_REQ=0, BLK_ADDR=0, BYTE_DATA=0, BYTE_VALID=0; state IDLE.
- ENA→BLK_REQ high: 2 cycles (IDLE→CHECK→REQ).
- BLK_GNT in the same cycle BLK_REQ rises is accepted. BLK_REQ drops the cycle after GNT.
- First BYTE_VALID appears the cycle after GNT. Outputs are registered.
- At full RDY, one byte per cycle: 512 cycles per block.
- RDY low: BYTE_DATA/BYTE_VALID are held stable and b does not advance.
- BLK_DONE outside WAIT_DONE is ignored. BLK_GNT outside REQ is ignored.
- Last BLK_DONE → COMPLT: 1 cycle (WAIT_DONE→DONE).
- RST mid-job: all outputs return to reset values on the next edge and the job is abandoned. A partially streamed block is not the block's concern; the controller owns cleanup.
- FIRST==EOF: valid job, one sector pair.

## Structure
- Package fat_pkg: BLOCK_BYTES, ENTRIES_PER_BLOCK, EOC_VALUE, reserved-entry constants 0x0FFFFFF8/0xFFFFFFFF, state enum (IDLE, CHECK, REQ, STREAM, WAIT_DONE, DONE).
- One sub-module: fatEntrySerializer.
  - Inputs: s, b, EOF, RDY-qualified advance.
  - Outputs: registered byte.
  - Owns the entry-value mux and byte-lane select.
  - Top level owns the FSM, the sector/FAT counters and the block handshake.

## Test plan
- FIRST=2, EOF=5, FAT1=14462, FAT2=15423, RDY tied 1 → two blocks, addresses 14462 then 15423.
  - Bytes 0–7: F8 FF FF 0F FF FF FF FF.
  - Bytes 8–11: 03 00 00 00.
  - Bytes 20–23: FF FF FF 0F.
  - Bytes 24–511: 00.
  - Identical payload in both blocks; COMPLT 1 cycle after the 2nd BLK_DONE; ERR=0.
- FIRST=100, EOF=300 → 6 blocks: 14462, 15423, 14463, 15424, 14464, 15425.
  - Sector 0 bytes 508–511: 80 00 00 00.
  - Sector 2 bytes 176–179: FF FF FF 0F; bytes 180+ are 0.
- FIRST=10, EOF=9 → COMPLT with ERR=1 within 3 cycles of ENA; BLK_REQ never rises.
- Random BYTE_RDY (~50%) and BLK_GNT delayed 7 cycles → payload identical to the RDY=1 case; data held stable while RDY=0.
- RST asserted at byte 200 of the first block → all outputs 0 next cycle; new ENA restarts cleanly from BLK_ADDR=FAT1.
- ENA pulsed repeatedly during STREAM → no effect; exactly one COMPLT per accepted job.
